pipe_stage_skid_reg: RTL and testbench

Parametrised pipeline stage register that replaces per-stage hand-written latch banks such as the EX/MEM register.
- Carries an arbitrary-width payload bundle between two pipeline stages under a valid/ready handshake.
- Two-entry skid buffer keeps throughput at 1 transfer/cycle while in_ready_o is driven from state only.
- Keeps the global busywait freeze used by the existing pipeline and adds a synchronous flush for branch/exception squash.

---
 rtl/pipe_stage_skid_reg.sv | 138 +++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Two-entry skid-buffered pipeline stage register with valid/ready handshake,
// global busywait freeze and synchronous flush.
//
// Parameters:
//   DATA_W    payload width in bits
//   RESET_VAL reset value of both data entries
//   CNT_W     stall counter width
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   busywait_i   global freeze, no transfer while high
//   flush_i      squash both entries (wins over busywait_i)
//   in_valid_i   upstream payload valid
//   in_ready_o   stage can accept (from state, busywait_i, flush_i only)
//   in_data_i    upstream payload
//   out_valid_o  main entry valid and not frozen
//   out_ready_i  downstream accepts
//   out_data_o   main entry payload (holds when out_valid_o is low)
//   occupancy_o  entries held, 0..2
//   stall_cnt_o  saturating count of stalled cycles
//
// Optional feature macro: PIPE_STAGE_STALL_CNT_EN enables the stall counter;
// without it stall_cnt_o is tied to zero.
module pipe_stage_skid_reg #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              busywait_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              main_valid_q;
  logic              main_valid_d;
  logic              skid_valid_q;
  logic              skid_valid_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic [1:0]        occ_q;
  logic              acc;
  logic              take;

  // Ready depends on skid state only, so upstream never sees
  // a combinational path from out_ready_i.
  assign in_ready_o  = !skid_valid_q && !busywait_i && !flush_i;
  assign out_valid_o = main_valid_q && !busywait_i;
  assign out_data_o  = main_q;
  assign occupancy_o = occ_q;

  assign acc  = in_valid_i && in_ready_o;
  assign take = out_valid_o && out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!busywait_i) begin
      unique case (1'b1)
        !main_valid_q && acc: begin
          main_d       = in_data_i;
          main_valid_d = 1'b1;
        end
        // acc implies skid empty, so new data goes straight to main
        main_valid_q && take && acc: begin
          main_d = in_data_i;
        end
        main_valid_q && take && !acc && skid_valid_q: begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end
        main_valid_q && take && !acc && !skid_valid_q: begin
          main_valid_d = 1'b0;
        end
        main_valid_q && !take && acc: begin
          skid_d       = in_data_i;
          skid_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= RESET_VAL;
      skid_q       <= RESET_VAL;
      occ_q        <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      occ_q        <= 2'(main_valid_d) + 2'(skid_valid_d);
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic             stall_inc;

  assign stall_inc = main_valid_q && !out_ready_i
                  && !busywait_i && !flush_i
                  && !(&stall_q);

  // Only reset clears the counter; flush leaves it alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (stall_inc) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg.
// Scoreboard queue checks ordering and occupancy every cycle.
module tb_pipe_stage_skid_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        busywait_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [1:0]  occupancy_o;
  logic [3:0]  stall_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

`ifdef PIPE_STAGE_STALL_CNT_EN
  localparam logic [3:0] EXP_C3  = 4'd3;
  localparam logic [3:0] EXP_SAT = 4'd15;
`else
  localparam logic [3:0] EXP_C3  = 4'd0;
  localparam logic [3:0] EXP_SAT = 4'd0;
`endif

  pipe_stage_skid_reg #(
    .DATA_W(32),
    .RESET_VAL(32'h0),
    .CNT_W(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .busywait_i(busywait_i),
    .flush_i(flush_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_data_i(in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o(out_data_o),
    .occupancy_o(occupancy_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Mid-cycle monitor: inputs change only just after posedge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      sb.delete();
    end else begin
      checks++;
      if (occupancy_o !== 2'(sb.size())) begin
        errors++;
        $display("FAIL sb_occ got %0d exp %0d", occupancy_o, sb.size());
      end
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty got %h exp none", out_data_o);
        end else if (out_data_o !== sb[0]) begin
          errors++;
          $display("FAIL sb_data got %h exp %h", out_data_o, sb[0]);
          void'(sb.pop_front());
        end else begin
          void'(sb.pop_front());
        end
      end
      if (in_valid_i && in_ready_o) sb.push_back(in_data_i);
      if (flush_i) sb.delete();
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    busywait_i  = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({out_valid_o, occupancy_o, out_data_o, stall_cnt_o} !== 39'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b occ=%0d d=%h c=%0d exp all 0",
               out_valid_o, occupancy_o, out_data_o, stall_cnt_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", in_ready_o);
    end
    cyc();
  endtask

  task automatic test_stream();
    out_ready_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = 32'(k);
      #1;
      checks++;
      if (in_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready%0d got %b exp 1", k, in_ready_o);
      end
      cyc();
      checks++;
      if ({out_valid_o, occupancy_o, out_data_o} !== {1'b1, 2'd1, 32'(k)}) begin
        errors++;
        $display("FAIL stream_out%0d got v=%b occ=%0d d=%h exp v=1 occ=1 d=%h",
                 k, out_valid_o, occupancy_o, out_data_o, k);
      end
    end
    in_valid_i = 1'b0;
    cyc();
    checks++;
    if ({out_valid_o, occupancy_o} !== 3'b000) begin
      errors++;
      $display("FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0",
               out_valid_o, occupancy_o);
    end
  endtask

  task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = a;
    cyc();
    in_data_i   = b;
    cyc();
    in_valid_i  = 1'b0;
  endtask

  task automatic test_skid();
    fill_two(32'h10, 32'h20);
    checks++;
    if ({occupancy_o, in_ready_o, out_data_o} !== {2'd2, 1'b0, 32'h10}) begin
      errors++;
      $display("FAIL skid_full got occ=%0d rdy=%b d=%h exp occ=2 rdy=0 d=10",
               occupancy_o, in_ready_o, out_data_o);
    end
    out_ready_i = 1'b1;
    cyc();
    checks++;
    if ({occupancy_o, in_ready_o, out_valid_o, out_data_o} !==
        {2'd1, 1'b1, 1'b1, 32'h20}) begin
      errors++;
      $display("FAIL skid_take1 got occ=%0d rdy=%b v=%b d=%h exp 1 1 1 20",
               occupancy_o, in_ready_o, out_valid_o, out_data_o);
    end
    cyc();
    checks++;
    if (occupancy_o !== 2'd0) begin
      errors++;
      $display("FAIL skid_take2 got occ=%0d exp 0", occupancy_o);
    end
  endtask

  task automatic test_busywait();
    fill_two(32'h10, 32'h20);
    busywait_i  = 1'b1;
    in_valid_i  = 1'b1;
    in_data_i   = 32'h99;
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({in_ready_o, out_valid_o, occupancy_o, out_data_o} !==
          {1'b0, 1'b0, 2'd2, 32'h10}) begin
        errors++;
        $display("FAIL busy_hold%0d got rdy=%b v=%b occ=%0d d=%h exp 0 0 2 10",
                 i, in_ready_o, out_valid_o, occupancy_o, out_data_o);
      end
      cyc();
    end
    busywait_i = 1'b0;
    in_valid_i = 1'b0;
    #1;
    checks++;
    if ({out_valid_o, out_data_o} !== {1'b1, 32'h10}) begin
      errors++;
      $display("FAIL busy_release got v=%b d=%h exp v=1 d=10",
               out_valid_o, out_data_o);
    end
    cyc();
    cyc();
  endtask

  task automatic test_flush();
    fill_two(32'h30, 32'h40);
    flush_i     = 1'b1;
    busywait_i  = 1'b1;
    in_valid_i  = 1'b1;
    in_data_i   = 32'h55;
    out_ready_i = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got %b exp 0", in_ready_o);
    end
    cyc();
    flush_i    = 1'b0;
    busywait_i = 1'b0;
    in_valid_i = 1'b0;
    #1;
    checks++;
    if ({occupancy_o, out_valid_o, in_ready_o, out_data_o} !==
        {2'd0, 1'b0, 1'b1, 32'h30}) begin
      errors++;
      $display("FAIL flush_state got occ=%0d v=%b rdy=%b d=%h exp 0 0 1 30",
               occupancy_o, out_valid_o, in_ready_o, out_data_o);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 32'hA5A5A5A5;
    cyc();
    in_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({out_valid_o, occupancy_o, out_data_o} !== 35'h0) begin
      errors++;
      $display("FAIL reset_mid got v=%b occ=%0d d=%h exp all 0",
               out_valid_o, occupancy_o, out_data_o);
    end
    cyc();
    rst_i = 1'b0;
    cyc();
  endtask

  task automatic test_counter();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    cyc();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 32'h77;
    cyc();
    in_valid_i = 1'b0;
    cyc();
    cyc();
    cyc();
    checks++;
    if (stall_cnt_o !== EXP_C3) begin
      errors++;
      $display("FAIL cnt_inc got %0d exp %0d", stall_cnt_o, EXP_C3);
    end
    for (int i = 0; i < 17; i++) cyc();
    checks++;
    if (stall_cnt_o !== EXP_SAT) begin
      errors++;
      $display("FAIL cnt_sat got %0d exp %0d", stall_cnt_o, EXP_SAT);
    end
    out_ready_i = 1'b1;
    cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    checks++;
    if (stall_cnt_o !== EXP_SAT) begin
      errors++;
      $display("FAIL cnt_keep got %0d exp %0d", stall_cnt_o, EXP_SAT);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      in_valid_i  = 1'($urandom_range(0, 1));
      in_data_i   = $urandom;
      out_ready_i = ($urandom_range(0, 3) != 0);
      busywait_i  = ($urandom_range(0, 9) == 0);
      cyc();
    end
    in_valid_i  = 1'b0;
    busywait_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 6 && sb.size() != 0; i++) cyc();
    cyc();
    checks++;
    if (sb.size() != 0 || occupancy_o !== 2'd0) begin
      errors++;
      $display("FAIL b2b_drain got left=%0d occ=%0d exp 0 0",
               sb.size(), occupancy_o);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_busywait();
    test_flush();
    test_reset_mid();
    test_counter();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
